// File: rtl/fir_scale_pkg.sv
// fir_scale_pkg: shared widths, shift limit, FSM encoding and clamp helper
// for the FIR output-scaler configuration sequencers.
package fir_scale_pkg;

   localparam int CFG_WIDTH = 24;
   localparam int SHIFT_MAX = 40;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_FIN       = 3'd3,
      S_ERR       = 3'd4
   } state_t;

   function automatic logic isSat(input logic [CFG_WIDTH-1:0] v);
      return v > CFG_WIDTH'(SHIFT_MAX);
   endfunction

   function automatic logic [CFG_WIDTH-1:0] clampShift(input logic [CFG_WIDTH-1:0] v);
      return isSat(v) ? CFG_WIDTH'(SHIFT_MAX) : v;
   endfunction

endpackage

// File: rtl/fir_cfg_timer.sv
// fir_cfg_timer: load/enable attempt timer with terminal-count flag.
// tc marks the cycle whose increment reaches TIMEOUT_CYCLES-1, so request cycle plus wait spans TIMEOUT_CYCLES.
module fir_cfg_timer #(
   parameter int TIMEOUT_CYCLES = 64,
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1
) (
   input  logic CLK,
   input  logic nRST,
   input  logic load,
   input  logic en,
   output logic tc
);

   logic [TW-1:0] count;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         count <= '0;
      else
         count <= load ? '0 : en ? count + 1'b1 : count;
   end

   assign tc = en && (count == TW'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/fir_scale_cfg_seq.sv
// fir_scale_cfg_seq: host-facing config sequencer for one FIR output scaler;
// clamps shift writes, drives isConfig/Done handshake with timeout/retry, buffers one pending write.
module fir_scale_cfg_seq
   import fir_scale_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MAX_RETRY      = 3
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 host_wr,
   input  logic [CFG_WIDTH-1:0] host_wdata,
   input  logic                 clear_err,
   output logic                 host_busy,
   output logic                 host_done,
   output logic                 host_err,
   output logic                 host_sat,
   output logic [CFG_WIDTH-1:0] active_shift,
   output logic                 cfg_req,
   output logic [CFG_WIDTH-1:0] cfg_data,
   input  logic                 cfg_ack,
   input  logic                 cfg_done
);

   localparam int RW = $clog2(MAX_RETRY + 2);

   state_t               state, nextState;
   logic [RW-1:0]        retryCnt;
   logic [CFG_WIDTH-1:0] pendData;
   logic                 pendValid;
   logic                 timerLoad, timerEn, timerTc;
   logic                 doneHit, retryHit, clearHit, consumePend, wrIdle, wrPend;
   logic                 unusedAck;

   assign unusedAck = cfg_ack;

   fir_cfg_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uTimer (
      .CLK  (CLK),
      .nRST (nRST),
      .load (timerLoad),
      .en   (timerEn),
      .tc   (timerTc)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state <= S_IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      timerLoad = 1'b0;
      timerEn   = 1'b0;
      case (state)
         S_IDLE:      nextState = host_wr ? S_REQ : S_IDLE;
         S_REQ: begin
            timerLoad = 1'b1;
            nextState = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            timerEn   = 1'b1;
            nextState = cfg_done ? S_FIN
                      : timerTc  ? (retryCnt < RW'(MAX_RETRY) ? S_REQ : S_ERR)
                      : S_WAIT_DONE;
         end
         S_FIN:       nextState = pendValid ? S_REQ : S_IDLE;
         S_ERR:       nextState = clear_err ? (pendValid ? S_REQ : S_IDLE) : S_ERR;
         default:     nextState = S_IDLE;
      endcase
   end

   assign doneHit     = (state == S_WAIT_DONE) && cfg_done;
   assign retryHit    = (state == S_WAIT_DONE) && !cfg_done && timerTc && (retryCnt < RW'(MAX_RETRY));
   assign clearHit    = (state == S_ERR) && clear_err;
   assign consumePend = pendValid && ((state == S_FIN) || clearHit);
   assign wrIdle      = host_wr && (state == S_IDLE);
   assign wrPend      = host_wr && (state != S_IDLE);

   // active_shift captures on the Done edge so it is visible alongside host_done in FIN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cfg_data     <= '0;
         pendData     <= '0;
         pendValid    <= 1'b0;
         host_sat     <= 1'b0;
         active_shift <= '0;
         retryCnt     <= '0;
      end else begin
         cfg_data     <= wrIdle ? clampShift(host_wdata) : consumePend ? pendData : cfg_data;
         pendData     <= wrPend ? clampShift(host_wdata) : pendData;
         pendValid    <= wrPend || (pendValid && !consumePend);
         host_sat     <= host_wr ? isSat(host_wdata) : host_sat;
         active_shift <= doneHit ? cfg_data : active_shift;
         retryCnt     <= (doneHit || clearHit) ? '0 : retryHit ? retryCnt + 1'b1 : retryCnt;
      end
   end

   assign cfg_req   = (state == S_REQ);
   assign host_done = (state == S_FIN);
   assign host_err  = (state == S_ERR);
   assign host_busy = ((state != S_IDLE) && (state != S_ERR)) || pendValid;

endmodule

// File: tb/tb_fir_scale_cfg_seq.sv
// tb_fir_scale_cfg_seq: directed checks of the scaler config sequencer against a
// 2-cycle Done scaler model, with timeout, pending-write and async-reset scenarios.
module tb_fir_scale_cfg_seq;
   import fir_scale_pkg::*;

   logic                 CLK = 1'b0;
   logic                 nRST = 1'b0;
   logic                 host_wr = 1'b0;
   logic [CFG_WIDTH-1:0] host_wdata = '0;
   logic                 clear_err = 1'b0;
   logic                 host_busy, host_done, host_err, host_sat, cfg_req;
   logic [CFG_WIDTH-1:0] active_shift, cfg_data;
   logic                 cfg_ack = 1'b0;
   logic                 cfg_done;
   logic                 manDone = 1'b0;
   logic                 scalerOn = 1'b1;
   logic                 modelD1, modelDone;

   int nCmp = 0;
   int nFail = 0;
   int cyc = 0;
   int doneCnt = 0;
   logic [CFG_WIDTH-1:0] doneVals[$];
   int reqCyc[$];

   fir_scale_cfg_seq #(.TIMEOUT_CYCLES(8), .MAX_RETRY(3)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .host_wr      (host_wr),
      .host_wdata   (host_wdata),
      .clear_err    (clear_err),
      .host_busy    (host_busy),
      .host_done    (host_done),
      .host_err     (host_err),
      .host_sat     (host_sat),
      .active_shift (active_shift),
      .cfg_req      (cfg_req),
      .cfg_data     (cfg_data),
      .cfg_ack      (cfg_ack),
      .cfg_done     (cfg_done)
   );

   always #5 CLK = ~CLK;

   // scaler model: Done two cycles after isConfig, reset by the shared nRST
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         modelD1   <= 1'b0;
         modelDone <= 1'b0;
      end else begin
         modelD1   <= cfg_req && scalerOn;
         modelDone <= modelD1;
      end
   end
   assign cfg_done = modelDone | manDone;

   always @(posedge CLK) begin
      cyc++;
      if (host_done) begin
         doneCnt++;
         doneVals.push_back(active_shift);
      end
      if (cfg_req) reqCyc.push_back(cyc);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [CFG_WIDTH-1:0] v);
      host_wr = 1'b1;
      host_wdata = v;
      tick();
      host_wr = 1'b0;
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      tick(2);
      nCmp++; if ({host_busy, host_done, host_err, host_sat, cfg_req} !== 5'b0) begin nFail++; $display("FAIL reset_flags: got %b want 00000", {host_busy, host_done, host_err, host_sat, cfg_req}); end
      nCmp++; if (active_shift !== '0) begin nFail++; $display("FAIL reset_active: got %0d want 0", active_shift); end
      nCmp++; if (cfg_data !== '0) begin nFail++; $display("FAIL reset_cfg_data: got %0d want 0", cfg_data); end
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      int d0 = doneCnt;
      wr(5);
      nCmp++; if (cfg_req !== 1'b1) begin nFail++; $display("FAIL basic_req_t1: got %b want 1", cfg_req); end
      nCmp++; if (cfg_data !== 24'd5) begin nFail++; $display("FAIL basic_cfg_data: got %0d want 5", cfg_data); end
      nCmp++; if (host_busy !== 1'b1) begin nFail++; $display("FAIL basic_busy: got %b want 1", host_busy); end
      tick();
      nCmp++; if (cfg_req !== 1'b0) begin nFail++; $display("FAIL basic_req_single: got %b want 0", cfg_req); end
      tick(2);
      nCmp++; if (host_done !== 1'b1) begin nFail++; $display("FAIL basic_done_t4: got %b want 1", host_done); end
      nCmp++; if (active_shift !== 24'd5) begin nFail++; $display("FAIL basic_active: got %0d want 5", active_shift); end
      tick();
      nCmp++; if ({host_done, host_busy} !== 2'b00) begin nFail++; $display("FAIL basic_idle_after: got %b want 00", {host_done, host_busy}); end
      nCmp++; if (doneCnt - d0 !== 1) begin nFail++; $display("FAIL basic_done_count: got %0d want 1", doneCnt - d0); end
   endtask

   task automatic test_sat;
      wr(100);
      nCmp++; if (cfg_data !== 24'd40) begin nFail++; $display("FAIL sat_clamp: got %0d want 40", cfg_data); end
      nCmp++; if (host_sat !== 1'b1) begin nFail++; $display("FAIL sat_flag: got %b want 1", host_sat); end
      tick(4);
      nCmp++; if (active_shift !== 24'd40) begin nFail++; $display("FAIL sat_active: got %0d want 40", active_shift); end
      wr(40);
      nCmp++; if (host_sat !== 1'b0) begin nFail++; $display("FAIL sat_boundary40: got %b want 0", host_sat); end
      tick(4);
      wr(7);
      nCmp++; if (host_sat !== 1'b0) begin nFail++; $display("FAIL sat_clear: got %b want 0", host_sat); end
      tick(3);
      nCmp++; if (active_shift !== 24'd7 || host_done !== 1'b1) begin nFail++; $display("FAIL sat_active7: got %0d/%b want 7/1", active_shift, host_done); end
      tick();
   endtask

   task automatic test_back_to_back;
      int d0 = doneCnt;
      int n0 = doneVals.size();
      wr(3);
      wr(9);
      wr(12);
      nCmp++; if (cfg_data !== 24'd3) begin nFail++; $display("FAIL b2b_data_held: got %0d want 3", cfg_data); end
      tick();
      nCmp++; if (host_done !== 1'b1 || active_shift !== 24'd3) begin nFail++; $display("FAIL b2b_first: got %b/%0d want 1/3", host_done, active_shift); end
      tick();
      nCmp++; if (cfg_req !== 1'b1 || cfg_data !== 24'd12) begin nFail++; $display("FAIL b2b_second_req: got %b/%0d want 1/12", cfg_req, cfg_data); end
      tick(6);
      nCmp++; if (doneCnt - d0 !== 2) begin nFail++; $display("FAIL b2b_done_count: got %0d want 2", doneCnt - d0); end
      if (doneVals.size() >= n0 + 2) begin
         nCmp++; if (doneVals[n0] !== 24'd3 || doneVals[n0+1] !== 24'd12) begin nFail++; $display("FAIL b2b_sequence: got %0d,%0d want 3,12", doneVals[n0], doneVals[n0+1]); end
      end
      nCmp++; if (host_busy !== 1'b0 || active_shift !== 24'd12) begin nFail++; $display("FAIL b2b_final: got %b/%0d want 0/12", host_busy, active_shift); end
   endtask

   task automatic test_timeout;
      int r0 = reqCyc.size();
      scalerOn = 1'b0;
      wr(6);
      tick(40);
      nCmp++; if (reqCyc.size() - r0 !== 4) begin nFail++; $display("FAIL to_req_count: got %0d want 4", reqCyc.size() - r0); end
      if (reqCyc.size() - r0 == 4) begin
         for (int i = 1; i < 4; i++) begin
            nCmp++; if (reqCyc[r0+i] - reqCyc[r0+i-1] !== 8) begin nFail++; $display("FAIL to_req_gap%0d: got %0d want 8", i, reqCyc[r0+i] - reqCyc[r0+i-1]); end
         end
      end
      nCmp++; if ({host_err, host_busy, cfg_req} !== 3'b100) begin nFail++; $display("FAIL to_err_state: got %b want 100", {host_err, host_busy, cfg_req}); end
      nCmp++; if (cfg_data !== 24'd6 || active_shift !== 24'd12) begin nFail++; $display("FAIL to_data_held: got %0d/%0d want 6/12", cfg_data, active_shift); end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      nCmp++; if ({host_err, host_busy} !== 2'b00) begin nFail++; $display("FAIL to_clear_idle: got %b want 00", {host_err, host_busy}); end
      wr(11);
      tick(40);
      scalerOn = 1'b1;
      wr(4);
      nCmp++; if ({host_err, host_busy} !== 2'b11) begin nFail++; $display("FAIL to_err_pending: got %b want 11", {host_err, host_busy}); end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      nCmp++; if (cfg_req !== 1'b1 || cfg_data !== 24'd4 || host_err !== 1'b0) begin nFail++; $display("FAIL to_clear_retry: got %b/%0d/%b want 1/4/0", cfg_req, cfg_data, host_err); end
      tick(3);
      nCmp++; if (host_done !== 1'b1 || active_shift !== 24'd4) begin nFail++; $display("FAIL to_pending_applied: got %b/%0d want 1/4", host_done, active_shift); end
      tick();
   endtask

   task automatic test_done_timeout;
      int r0;
      scalerOn = 1'b0;
      wr(8);
      tick(7);
      manDone = 1'b1;
      r0 = reqCyc.size();
      tick();
      manDone = 1'b0;
      nCmp++; if (host_done !== 1'b1 || active_shift !== 24'd8) begin nFail++; $display("FAIL dt_done_wins: got %b/%0d want 1/8", host_done, active_shift); end
      tick(3);
      nCmp++; if (reqCyc.size() !== r0 || host_busy !== 1'b0) begin nFail++; $display("FAIL dt_no_retry: got %0d/%b want %0d/0", reqCyc.size(), host_busy, r0); end
      scalerOn = 1'b1;
      manDone = 1'b1;
      tick();
      manDone = 1'b0;
      nCmp++; if ({host_busy, host_done, cfg_req} !== 3'b000) begin nFail++; $display("FAIL dt_spurious: got %b want 000", {host_busy, host_done, cfg_req}); end
      tick();
      nCmp++; if (host_done !== 1'b0 || active_shift !== 24'd8) begin nFail++; $display("FAIL dt_spurious_after: got %b/%0d want 0/8", host_done, active_shift); end
   endtask

   task automatic test_reset_mid;
      int d0 = doneCnt;
      wr(100);
      tick();
      #2 nRST = 1'b0;
      #1;
      nCmp++; if ({host_busy, host_done, host_err, host_sat, cfg_req} !== 5'b0) begin nFail++; $display("FAIL rst_mid_flags: got %b want 00000", {host_busy, host_done, host_err, host_sat, cfg_req}); end
      nCmp++; if (active_shift !== '0 || cfg_data !== '0) begin nFail++; $display("FAIL rst_mid_data: got %0d/%0d want 0/0", active_shift, cfg_data); end
      tick(3);
      nRST = 1'b1;
      tick();
      nCmp++; if (doneCnt !== d0) begin nFail++; $display("FAIL rst_mid_no_done: got %0d want %0d", doneCnt, d0); end
      wr(2);
      nCmp++; if (cfg_req !== 1'b1 || cfg_data !== 24'd2) begin nFail++; $display("FAIL rst_after_req: got %b/%0d want 1/2", cfg_req, cfg_data); end
      tick(3);
      nCmp++; if (host_done !== 1'b1 || active_shift !== 24'd2) begin nFail++; $display("FAIL rst_after_done: got %b/%0d want 1/2", host_done, active_shift); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sat();
      test_back_to_back();
      test_timeout();
      test_done_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
